// File: rtl/toy_fetch_unit_pkg.sv
// Shared definitions for the toy accumulator CPU fetch stage.
package toy_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned INSTR_W_DEF = 12;

  // Opcode field values seen by the fetch stage
  localparam logic [3:0] OP_JMP     = 4'b0000;
  localparam logic [3:0] OP_ADC     = 4'b0001;
  localparam logic [3:0] OP_ILLEGAL = 4'b0111;
  localparam logic [3:0] OP_STA     = 4'b1111;

  // Next-PC source select driven by the controller
  typedef enum logic [1:0] {
    PC_INC  = 2'b00,
    PC_JMP  = 2'b01,
    PC_BR   = 2'b10,
    PC_HOLD = 2'b11
  } src_pc_e;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_WAIT  = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/toy_fetch_unit_next_pc.sv
// Combinational next-PC selection: increment, jump, conditional branch or hold.
module toy_next_pc
  import toy_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic [1:0]        src_pc_i,
  input  logic              cond_true_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              halt_o
);

  logic [ADDR_W-1:0] pc_inc;

  // Increment wraps naturally at 2^ADDR_W
  assign pc_inc = pc_i + ADDR_W'(1);

  // Select the next PC from the controller's source code
  always_comb begin
    next_pc_o = pc_inc;
    halt_o    = 1'b0;
    case (src_pc_e'(src_pc_i))
      PC_INC:  next_pc_o = pc_inc;
      PC_JMP:  next_pc_o = target_i;
      PC_BR:   next_pc_o = cond_true_i ? target_i : pc_inc;
      PC_HOLD: begin
        next_pc_o = pc_i;
        halt_o    = 1'b1;
      end
      default: next_pc_o = pc_inc;
    endcase
  end

endmodule

// File: rtl/toy_fetch_unit.sv
// Instruction fetch/sequencing stage: owns the PC, fetches into the IR and
// presents opcode/operand to the controller until it reports ex_done.
module toy_fetch_unit
  import toy_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic [1:0]         src_pc,
  input  logic               cond_true,
  input  logic               ex_done,
  output logic [3:0]         opcode,
  output logic [INSTR_W-5:0] operand,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               illegal
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               req_q;
  logic               ir_valid_q;
  logic               halted_q, halted_d;
  logic               illegal_q, illegal_d;

  logic [ADDR_W-1:0]  op_addr;
  logic [ADDR_W-1:0]  next_pc;
  logic               halt_req;

  assign op_addr = ADDR_W'(ir_q[INSTR_W-5:0]);

  toy_next_pc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc_i        (pc_q),
    .target_i    (op_addr),
    .src_pc_i    (src_pc),
    .cond_true_i (cond_true),
    .next_pc_o   (next_pc),
    .halt_o      (halt_req)
  );

  // Sequencer next-state, PC, IR and sticky status
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      // Grant only counts once the request is actually driven, so the first
      // cycle out of reset (request still low) cannot launch a fetch.
      ST_FETCH: if (req_q && imem_gnt) state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid) begin
          ir_d = imem_rdata;
          if (imem_rdata[INSTR_W-1 -: 4] == OP_ILLEGAL) begin
            state_d   = ST_HALT;
            halted_d  = 1'b1;
            illegal_d = 1'b1;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      // src_pc/cond_true only reach the PC on the ex_done cycle
      ST_EXEC: begin
        if (ex_done) begin
          pc_d = next_pc;
          if (halt_req) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      req_q      <= 1'b0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      req_q      <= (state_d == ST_FETCH);
      ir_valid_q <= (state_d == ST_EXEC);
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign opcode    = ir_q[INSTR_W-1 -: 4];
  assign operand   = ir_q[INSTR_W-5:0];
  assign ir_valid  = ir_valid_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_toy_fetch_unit.sv
// Self-checking bench for toy_fetch_unit: drives a memory/controller from
// instruction-level transactions and checks every cycle against a PC model.
module tb_toy_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [11:0] imem_rdata;
  logic [1:0]  src_pc;
  logic        cond_true;
  logic        ex_done;
  logic [3:0]  opcode;
  logic [7:0]  operand;
  logic        ir_valid;
  logic [7:0]  pc;
  logic        halted;
  logic        illegal;

  toy_fetch_unit #(
    .ADDR_W   (8),
    .INSTR_W  (12),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .src_pc      (src_pc),
    .cond_true   (cond_true),
    .ex_done     (ex_done),
    .opcode      (opcode),
    .operand     (operand),
    .ir_valid    (ir_valid),
    .pc          (pc),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // Protocol phase as seen by the bench's memory/controller
  localparam int P_RESET = 0;
  localparam int P_START = 1;
  localparam int P_FETCH = 2;
  localparam int P_WAIT  = 3;
  localparam int P_EXEC  = 4;
  localparam int P_HALT  = 5;

  int          total = 0;
  int          bad = 0;
  bit          running = 1'b1;
  int          phase = P_RESET;
  int unsigned m_pc = 0;
  logic        m_halted = 1'b0;
  logic        m_illegal = 1'b0;
  logic [11:0] m_word = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (running) begin
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("halted", halted, m_halted);
      chk("illegal", illegal, m_illegal);
      chk("ir_valid", ir_valid, phase == P_EXEC);
      if (phase == P_EXEC) begin
        chk("opcode", opcode, m_word[11:8]);
        chk("operand", operand, m_word[7:0]);
      end
      if (phase == P_RESET) begin
        chk("rst_opcode", opcode, 0);
        chk("rst_operand", operand, 0);
      end
      if (phase == P_FETCH) chk("imem_req", imem_req, 1);
      else if (phase != P_START) chk("imem_req", imem_req, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit stale);
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    ex_done     = 1'b0;
    phase       = P_RESET;
    m_pc        = 0;
    m_halted    = 1'b0;
    m_illegal   = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    phase = P_START;
    if (stale) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 12'h7FF;
      step();
      imem_rvalid = 1'b0;
    end
  endtask

  task automatic wait_req(output bit ok);
    int unsigned n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    ok = (imem_req === 1'b1);
    if (!ok) chk("req_timeout", 0, 1);
    else phase = P_FETCH;
  endtask

  task automatic do_instr(input logic [11:0] w, input int unsigned gd, input int unsigned rd,
                          input int unsigned ed, input logic [1:0] src, input logic cnd,
                          output logic [7:0] a_seen, output logic [3:0] op_seen,
                          output logic [7:0] opd_seen);
    bit ok;
    a_seen = '0; op_seen = '0; opd_seen = '0;
    wait_req(ok);
    if (!ok) return;
    a_seen = imem_addr;
    repeat (gd) step();
    // Grant cycle also carries a bogus rvalid, which must be ignored
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 12'($urandom);
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    phase       = P_WAIT;
    repeat (rd) step();
    imem_rvalid = 1'b1;
    imem_rdata  = w;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 12'($urandom);
    op_seen  = opcode;
    opd_seen = operand;
    if (w[11:8] == 4'h7) begin
      phase     = P_HALT;
      m_halted  = 1'b1;
      m_illegal = 1'b1;
      return;
    end
    phase  = P_EXEC;
    m_word = w;
    repeat (ed) begin
      src_pc    = 2'($urandom);
      cond_true = 1'($urandom);
      step();
    end
    ex_done   = 1'b1;
    src_pc    = src;
    cond_true = cnd;
    step();
    ex_done   = 1'b0;
    src_pc    = 2'($urandom);
    cond_true = 1'($urandom);
    case (src)
      2'd0: m_pc = (m_pc + 1) % 256;
      2'd1: m_pc = w % 256;
      2'd2: m_pc = cnd ? (w % 256) : (m_pc + 1) % 256;
      default: m_halted = 1'b1;
    endcase
    phase = m_halted ? P_HALT : P_FETCH;
  endtask

  initial begin
    logic [7:0]  a;
    logic [3:0]  o;
    logic [7:0]  d;
    logic [11:0] w;
    bit          ok;
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    src_pc = '0; cond_true = 1'b0; ex_done = 1'b0;
    do_reset(1'b0);

    // Zero-wait ADC
    do_instr(12'h105, 0, 0, 0, 2'b00, 1'b0, a, o, d);
    chk("adc_addr", a, 8'h00);
    chk("adc_opcode", o, 4'b0001);
    chk("adc_operand", d, 8'h05);
    chk("adc_pc", pc, 8'h01);

    // JMP, then taken and not-taken branch
    do_instr(12'h03C, 0, 0, 0, 2'b01, 1'b0, a, o, d);
    chk("jmp_addr", imem_addr, 8'h3C);
    do_instr(12'h250, 0, 0, 1, 2'b10, 1'b1, a, o, d);
    chk("br_taken_pc", pc, 8'h50);
    do_instr(12'h210, 1, 0, 0, 2'b10, 1'b0, a, o, d);
    chk("br_not_taken_pc", pc, 8'h51);

    // Wrap from 0xFF
    do_instr(12'h0FF, 0, 0, 0, 2'b01, 1'b0, a, o, d);
    do_instr(12'h101, 0, 0, 0, 2'b00, 1'b0, a, o, d);
    chk("wrap_prev_addr", a, 8'hFF);
    chk("wrap_addr", imem_addr, 8'h00);

    // Memory and execute stalls
    do_instr(12'h1C3, 3, 1, 4, 2'b00, 1'b0, a, o, d);
    chk("stall_pc", pc, 8'h01);

    // Randomised instruction stream
    for (int i = 0; i < 40; i++) begin
      w = 12'($urandom);
      if (w[11:8] == 4'h7) w[11:8] = 4'h1;
      do_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               2'($urandom_range(0, 2)), 1'($urandom), a, o, d);
    end

    // Illegal opcode
    do_instr(12'h700, 0, 1, 0, 2'b00, 1'b0, a, o, d);
    chk("ill_illegal", illegal, 1);
    chk("ill_halted", halted, 1);
    chk("ill_req", imem_req, 0);
    repeat (5) step();

    // Halt via src_pc=11 freezes pc without illegal
    do_reset(1'b0);
    do_instr(12'h1AA, 0, 0, 0, 2'b00, 1'b0, a, o, d);
    do_instr(12'h1AB, 0, 0, 2, 2'b11, 1'b1, a, o, d);
    chk("hold_pc", pc, 8'h01);
    chk("hold_halted", halted, 1);
    chk("hold_illegal", illegal, 0);
    repeat (5) step();

    // Reset during WAIT, stale rvalid afterwards
    do_reset(1'b0);
    do_instr(12'h0F0, 0, 0, 0, 2'b01, 1'b0, a, o, d);
    wait_req(ok);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    phase    = P_WAIT;
    step();
    do_reset(1'b1);
    chk("stale_illegal", illegal, 0);
    do_instr(12'h122, 0, 0, 0, 2'b00, 1'b0, a, o, d);
    chk("stale_refetch_addr", a, 8'h00);
    chk("stale_operand", d, 8'h22);
    chk("stale_pc", pc, 8'h01);

    running = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
